// File: rtl/stage_id_hz.sv
// Decode stage: IF/ID register, register file with write-through bypass and a
// load-use hazard scoreboard that holds fetch and bubbles execute.
module stage_id_hz #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LOAD_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WORD_WIDTH-1:0]     inst_in,
    input  logic [ADDR_WIDTH-1:0]     pc_in,
    input  logic                      flush,
    input  logic                      ex_stall,
    input  logic                      wb_wen,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [WORD_WIDTH-1:0]     wb_data,
    output logic                      out_valid,
    output logic [WORD_WIDTH-1:0]     inst_out,
    output logic [ADDR_WIDTH-1:0]     pc_out,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0]     rs1_val,
    output logic [WORD_WIDTH-1:0]     rs2_val,
    output logic                      if_stall,
    output logic                      hazard
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam logic [WORD_WIDTH-1:0] NopInst = WORD_WIDTH'(32'h0000_0013);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;

    logic                      id_valid_q;
    logic [WORD_WIDTH-1:0]     inst_q;
    logic [ADDR_WIDTH-1:0]     pc_q;
    logic [LOAD_LATENCY-1:0]   sb_v_q;
    logic [REG_ADDR_WIDTH-1:0] sb_rd_q [LOAD_LATENCY];
    logic [WORD_WIDTH-1:0]     rf_q [NumRegs];

    logic [6:0] opcode;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       dep_hit;
    logic       load_issue;

    assign opcode   = inst_q[6:0];
    assign rs1_addr = inst_q[15 +: REG_ADDR_WIDTH];
    assign rs2_addr = inst_q[20 +: REG_ADDR_WIDTH];
    assign rd_addr  = inst_q[7 +: REG_ADDR_WIDTH];
    assign inst_out = inst_q;
    assign pc_out   = pc_q;

    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        if (opcode == OpLui || opcode == OpAuipc || opcode == OpJal) begin
            uses_rs1 = 1'b0;
        end
        if (opcode == OpReg || opcode == OpStore || opcode == OpBranch) begin
            uses_rs2 = 1'b1;
        end
    end

    // x0 is never a dependency, regardless of what the scoreboard holds.
    always_comb begin
        dep_hit = 1'b0;
        for (int k = 0; k < LOAD_LATENCY; k++) begin
            if (sb_v_q[k]) begin
                if (uses_rs1 && rs1_addr != '0 && sb_rd_q[k] == rs1_addr) dep_hit = 1'b1;
                if (uses_rs2 && rs2_addr != '0 && sb_rd_q[k] == rs2_addr) dep_hit = 1'b1;
            end
        end
    end

    assign hazard     = id_valid_q & dep_hit;
    assign out_valid  = id_valid_q & ~hazard;
    assign if_stall   = ex_stall | hazard;
    assign load_issue = out_valid & (opcode == OpLoad) & (rd_addr != '0);

    // Flush clears the valid bit even while the register is otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            inst_q     <= NopInst;
            pc_q       <= '0;
        end else begin
            if (!if_stall) begin
                id_valid_q <= in_valid;
                inst_q     <= inst_in;
                pc_q       <= pc_in;
            end
            if (flush) begin
                id_valid_q <= 1'b0;
            end
        end
    end

    // Entry k holds a load issued k+1 unstalled cycles ago; ex_stall freezes aging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v_q <= '0;
            for (int k = 0; k < LOAD_LATENCY; k++) begin
                sb_rd_q[k] <= '0;
            end
        end else if (!ex_stall) begin
            for (int k = LOAD_LATENCY - 1; k > 0; k--) begin
                sb_v_q[k]  <= sb_v_q[k-1];
                sb_rd_q[k] <= sb_rd_q[k-1];
            end
            sb_v_q[0]  <= load_issue;
            sb_rd_q[0] <= rd_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NumRegs; r++) begin
                rf_q[r] <= '0;
            end
        end else if (wb_wen && wb_addr != '0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs1_val = rf_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_val = '0;
        end else if (wb_wen && wb_addr == rs1_addr) begin
            rs1_val = wb_data;
        end
    end

    always_comb begin
        rs2_val = rf_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_val = '0;
        end else if (wb_wen && wb_addr == rs2_addr) begin
            rs2_val = wb_data;
        end
    end

endmodule

// File: tb/tb_stage_id_hz.sv
// Scoreboarded bench for stage_id_hz: one instance with LOAD_LATENCY=1 and one with 3,
// sharing stimulus; only the instance under test is out of reset at any time.
module tb_stage_id_hz;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    localparam logic [31:0] IAddi  = 32'h0050_0093;
    localparam logic [31:0] IAdd4  = 32'h0031_8233;
    localparam logic [31:0] ILw5   = 32'h0000_2283;
    localparam logic [31:0] IAdd6  = 32'h0002_8333;
    localparam logic [31:0] ILw0   = 32'h0000_2003;
    localparam logic [31:0] IAddX0 = 32'h0000_00b3;
    localparam logic [31:0] ILw7   = 32'h0000_2383;
    localparam logic [31:0] INop   = 32'h0000_0013;
    localparam logic [31:0] ISw7   = 32'h0070_2023;
    localparam logic [31:0] Dead   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        in_valid, flush, ex_stall, wb_wen;
    logic [31:0] inst_in, pc_in, wb_data;
    logic [4:0]  wb_addr;

    logic        o1_valid, o1_if_stall, o1_hazard;
    logic [31:0] o1_inst, o1_pc, o1_rs1v, o1_rs2v;
    logic [4:0]  o1_rs1a, o1_rs2a, o1_rda;
    logic        o3_valid, o3_if_stall, o3_hazard;
    logic [31:0] o3_inst, o3_pc, o3_rs1v, o3_rs2v;
    logic [4:0]  o3_rs1a, o3_rs2a, o3_rda;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   use3 = 1'b0;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    stage_id_hz #(.LOAD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid), .inst_in(inst_in), .pc_in(pc_in),
        .flush(flush), .ex_stall(ex_stall), .wb_wen(wb_wen), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(o1_valid), .inst_out(o1_inst), .pc_out(o1_pc),
        .rs1_addr(o1_rs1a), .rs2_addr(o1_rs2a), .rd_addr(o1_rda), .rs1_val(o1_rs1v),
        .rs2_val(o1_rs2v), .if_stall(o1_if_stall), .hazard(o1_hazard)
    );

    stage_id_hz #(.LOAD_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid), .inst_in(inst_in), .pc_in(pc_in),
        .flush(flush), .ex_stall(ex_stall), .wb_wen(wb_wen), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(o3_valid), .inst_out(o3_inst), .pc_out(o3_pc),
        .rs1_addr(o3_rs1a), .rs2_addr(o3_rs2a), .rd_addr(o3_rda), .rs1_val(o3_rs1v),
        .rs2_val(o3_rs2v), .if_stall(o3_if_stall), .hazard(o3_hazard)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction to fetch; if it is expected to issue, queue its record.
    task automatic drv(input logic [31:0] i, input logic [31:0] p, input bit issues,
                       input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        in_valid = 1'b1;
        inst_in  = i;
        pc_in    = p;
        e = '{pc: p, inst: i, rs1: r1, rs2: r2};
        if (issues) begin
            if (use3) q3.push_back(e);
            else      q1.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon_l1
        exp_t e;
        if (o1_valid && !ex_stall) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL l1_unexpected_issue: got pc %h, expected no issue", o1_pc);
            end else begin
                e = q1.pop_front();
                chk("l1_pc", o1_pc, e.pc);
                chk("l1_inst", o1_inst, e.inst);
                chk("l1_rs1_val", o1_rs1v, e.rs1);
                chk("l1_rs2_val", o1_rs2v, e.rs2);
            end
        end
    end

    always @(negedge clk) begin : mon_l3
        exp_t e;
        if (o3_valid && !ex_stall) begin
            if (q3.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL l3_unexpected_issue: got pc %h, expected no issue", o3_pc);
            end else begin
                e = q3.pop_front();
                chk("l3_pc", o3_pc, e.pc);
                chk("l3_inst", o3_inst, e.inst);
                chk("l3_rs1_val", o3_rs1v, e.rs1);
                chk("l3_rs2_val", o3_rs2v, e.rs2);
            end
        end
    end

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        in_valid = 1'b0; inst_in = '0; pc_in = '0;
        flush = 1'b0; ex_stall = 1'b0;
        wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();

        // Reset state of both instances.
        @(negedge clk);
        chk("rst_l1_valid", {31'b0, o1_valid}, 0);
        chk("rst_l1_hazard", {31'b0, o1_hazard}, 0);
        chk("rst_l1_inst", o1_inst, INop);
        chk("rst_l1_pc", o1_pc, 0);
        chk("rst_l3_valid", {31'b0, o3_valid}, 0);
        chk("rst_l3_inst", o3_inst, INop);
        ex_stall = 1'b1;
        #1;
        chk("rst_l1_if_stall_follows", {31'b0, o1_if_stall}, 1);
        chk("rst_l3_if_stall_follows", {31'b0, o3_if_stall}, 1);
        ex_stall = 1'b0;
        #1;
        chk("rst_l1_if_stall_idle", {31'b0, o1_if_stall}, 0);

        // ---------------- LOAD_LATENCY = 1 ----------------
        @(negedge clk);
        rst1 = 1'b0;
        drv(IAddi, 32'h100, 1, 0, 0);
        tick();
        drv(IAdd4, 32'h104, 1, Dead, Dead);
        @(negedge clk);
        chk("l1_addi_valid", {31'b0, o1_valid}, 1);
        chk("l1_addi_rd", {27'b0, o1_rda}, 1);
        chk("l1_addi_pc", o1_pc, 32'h100);
        tick();
        wb_wen = 1'b1; wb_addr = 5'd3; wb_data = Dead;
        drv(ILw5, 32'h108, 1, 0, 0);
        @(negedge clk);
        chk("l1_bypass_rs1", o1_rs1v, Dead);
        chk("l1_bypass_rs2", o1_rs2v, Dead);
        tick();
        wb_wen = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
        drv(IAdd6, 32'h10C, 1, 0, 0);
        @(negedge clk);
        chk("l1_x0_write_bypass", o1_rs1v, 0);
        chk("l1_lw_no_hazard", {31'b0, o1_hazard}, 0);
        tick();
        wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        @(negedge clk);
        chk("l1_lu_hazard", {31'b0, o1_hazard}, 1);
        chk("l1_lu_if_stall", {31'b0, o1_if_stall}, 1);
        chk("l1_lu_bubble", {31'b0, o1_valid}, 0);
        chk("l1_lu_rs1_addr", {27'b0, o1_rs1a}, 5);
        tick();
        drv(ILw0, 32'h110, 1, 0, 0);
        @(negedge clk);
        chk("l1_lu_released", {31'b0, o1_hazard}, 0);
        chk("l1_lu_issue", {31'b0, o1_valid}, 1);
        chk("l1_lu_issue_pc", o1_pc, 32'h10C);
        tick();
        drv(IAddX0, 32'h114, 1, 0, 0);
        @(negedge clk);
        chk("l1_lw_x0_valid", {31'b0, o1_valid}, 1);
        tick();
        drv(IAdd4, 32'h118, 1, Dead, Dead);
        @(negedge clk);
        chk("l1_x0_reader_no_hazard", {31'b0, o1_hazard}, 0);
        chk("l1_x0_reader_valid", {31'b0, o1_valid}, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("l1_rf_x3", o1_rs1v, Dead);
        tick();
        @(negedge clk);
        chk("l1_drain_bubble", {31'b0, o1_valid}, 0);
        tick();
        rst1 = 1'b1;

        // ---------------- LOAD_LATENCY = 3 ----------------
        use3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        drv(ILw7, 32'h200, 1, 0, 0);
        tick();
        drv(INop, 32'h204, 1, 0, 0);
        @(negedge clk);
        chk("l3_lw_valid", {31'b0, o3_valid}, 1);
        tick();
        drv(ISw7, 32'h208, 1, 0, 0);
        @(negedge clk);
        chk("l3_nop_no_hazard", {31'b0, o3_hazard}, 0);
        tick();
        @(negedge clk);
        chk("l3_d2_stall1", {31'b0, o3_hazard}, 1);
        chk("l3_d2_if_stall1", {31'b0, o3_if_stall}, 1);
        tick();
        @(negedge clk);
        chk("l3_d2_stall2", {31'b0, o3_hazard}, 1);
        tick();
        drv(ILw7, 32'h20C, 1, 0, 0);
        @(negedge clk);
        chk("l3_d2_released", {31'b0, o3_hazard}, 0);
        chk("l3_d2_issue_pc", o3_pc, 32'h208);
        tick();
        drv(INop, 32'h210, 1, 0, 0);
        @(negedge clk);
        chk("l3_lw2_valid", {31'b0, o3_valid}, 1);
        tick();
        drv(ISw7, 32'h214, 1, 0, 0);
        tick();
        ex_stall = 1'b1;
        @(negedge clk);
        chk("l3_exs_stall1", {31'b0, o3_hazard}, 1);
        tick();
        ex_stall = 1'b0;
        @(negedge clk);
        chk("l3_exs_frozen", {31'b0, o3_hazard}, 1);
        tick();
        @(negedge clk);
        chk("l3_exs_stall3", {31'b0, o3_hazard}, 1);
        tick();
        drv(ILw7, 32'h220, 1, 0, 0);
        @(negedge clk);
        chk("l3_exs_released", {31'b0, o3_hazard}, 0);
        chk("l3_exs_issue_pc", o3_pc, 32'h214);
        tick();
        drv(ISw7, 32'h224, 0, 0, 0);
        tick();
        flush = 1'b1;
        drv(ISw7, 32'h300, 1, 0, 0);
        @(negedge clk);
        chk("l3_flush_pre_hazard", {31'b0, o3_hazard}, 1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("l3_flush_hazard_drop", {31'b0, o3_hazard}, 0);
        chk("l3_flush_bubble", {31'b0, o3_valid}, 0);
        chk("l3_flush_fetch_resume", {31'b0, o3_if_stall}, 0);
        tick();
        @(negedge clk);
        chk("l3_sb_survives_flush", {31'b0, o3_hazard}, 1);
        tick();
        drv(ILw7, 32'h400, 1, 0, 0);
        @(negedge clk);
        chk("l3_sb_aged_out", {31'b0, o3_hazard}, 0);
        chk("l3_post_flush_pc", o3_pc, 32'h300);
        tick();
        drv(ISw7, 32'h404, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("l3_pre_rst_hazard", {31'b0, o3_hazard}, 1);
        #2;
        rst3 = 1'b1;
        #1;
        chk("l3_midrst_valid", {31'b0, o3_valid}, 0);
        chk("l3_midrst_hazard", {31'b0, o3_hazard}, 0);
        chk("l3_midrst_if_stall", {31'b0, o3_if_stall}, 0);
        chk("l3_midrst_inst", o3_inst, INop);
        chk("l3_midrst_pc", o3_pc, 0);
        drv(ISw7, 32'h408, 1, 0, 0);
        @(negedge clk);
        rst3 = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("l3_post_rst_no_hazard", {31'b0, o3_hazard}, 0);
        chk("l3_post_rst_issue", {31'b0, o3_valid}, 1);
        tick();
        tick();
        @(negedge clk);
        chk("l1_queue_drained", q1.size(), 0);
        chk("l3_queue_drained", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_id_hz.md
# stage_id_hz

Parametrised decode stage with a built-in IF/ID pipeline register, register file, valid/flush/stall handshake and a load-use hazard scoreboard of configurable depth. It sits between the fetch stage and the execute stage. It holds fetch and inserts bubbles into execute whenever an instruction in decode reads a register still being produced by an in-flight load.

## Interface
Parameters:
- WORD_WIDTH, 32, instruction and data word width
- ADDR_WIDTH, 32, program-counter width
- REG_ADDR_WIDTH, 5, register index width; register file has 2**REG_ADDR_WIDTH entries
- LOAD_LATENCY, 1, cycles after issue before a load result is forwardable (≥1); also the scoreboard depth

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents a valid instruction
- inst_in  in  WORD_WIDTH  fetched instruction
- pc_in  in  ADDR_WIDTH  address of inst_in
- flush  in  1  kill the instruction in decode (taken branch/jump in execute)
- ex_stall  in  1  execute cannot accept; freeze decode
- wb_wen  in  1  writeback write enable
- wb_addr  in  REG_ADDR_WIDTH  writeback destination
- wb_data  in  WORD_WIDTH  writeback value
- out_valid  out  1  decode output is a real instruction, not a bubble
- inst_out / pc_out  out  WORD_WIDTH / ADDR_WIDTH  contents of the ID register
- rs1_addr, rs2_addr, rd_addr  out  REG_ADDR_WIDTH  inst[19:15], inst[24:20], inst[11:7]
- rs1_val, rs2_val  out  WORD_WIDTH  register operands, bypassed
- if_stall  out  1  fetch must hold pc_in/inst_in
- hazard  out  1  load-use stall active this cycle

## Operation
- ID register is {id_valid, inst, pc}.
  - Loads in_valid/inst_in/pc_in on every edge where if_stall=0.
  - flush=1 forces id_valid←0 and overrides hold.
- Source use, from opcode inst[6:0]:
  - uses_rs1 = 0 for 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL); 1 otherwise.
  - uses_rs2 = 1 for 0110011, 0100011 and 1100011 only.
  - Index 0 is never a dependency.
- Scoreboard: LOAD_LATENCY-entry shift register of {v, rd}.
  - Each edge with ex_stall=0, entry k+1←entry k and the oldest entry drops.
  - Entry 0←{1, rd} if the issuing instruction has opcode 0000011 and rd≠0; otherwise entry 0←{0, x}.
  - ex_stall=1 freezes the scoreboard.
  - flush does not touch the scoreboard.
- hazard = id_valid & any valid entry whose rd equals rs1 (with uses_rs1) or rs2 (with uses_rs2).
- Outputs:
  - out_valid = id_valid & ~hazard.
  - if_stall = ex_stall | hazard.
  - An issue event is out_valid & ~ex_stall.
- Register file:
  - Written on an edge when wb_wen=1 and wb_addr≠0.
  - Reads are combinational; x0 reads 0.
  - Write-through bypass: if wb_wen & wb_addr==rsN & rsN≠0, rsN_val=wb_data.
- Simultaneous flush and hazard: flush wins. id_valid→0, so hazard drops next cycle; fetch resumes.

## Timing
- One cycle from inst_in capture to out_valid.
- Decode outputs and hazard are combinational from the ID register, scoreboard and writeback inputs.
- Load-use stall length: a consumer that directly follows a load sees hazard for LOAD_LATENCY cycles. At distance d (1≤d≤LOAD_LATENCY), it stalls LOAD_LATENCY−d+1 cycles.
- Stall cycles are counted only when ex_stall=0; cycles with ex_stall=1 add no progress.
- Reset (asynchronous, held while rst=1):
  - id_valid=0, inst=32'h00000013, pc=0.
  - Every scoreboard entry invalid; every register-file entry 0.
  - Hence out_valid=0, hazard=0, if_stall=ex_stall.
- Reset asserted mid-stall abandons the stall immediately; the first instruction after release issues with no hazard.

## Test plan
- Reset then stream ADDI x1,x0,5 (0x00500093) → out_valid=1 the cycle after capture; rd_addr=1, pc_out=pc_in.
- WB x3=0xDEADBEEF with ADD x4,x3,x3 in decode in the same cycle → rs1_val=rs2_val=0xDEADBEEF via bypass; write to x0 → x0 still reads 0.
- LOAD_LATENCY=1: LW x5 followed by ADD x6,x5,x0 → hazard=1 and if_stall=1 for exactly 1 cycle, with out_valid=0 that cycle; ADD issues next cycle. LW x0 followed by a reader of x0 → no stall.
- LOAD_LATENCY=3: LW x7; NOP; SW x7 → 2 stall cycles. An ex_stall pulse inside the stall extends it by the pulse length.
- Hazard active, then flush=1 → id_valid=0 and hazard=0 next cycle; fetch resumes; scoreboard entry still ages out.
- Assert rst mid-stall → all outputs at reset values immediately; scoreboard empty after release.
